change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 119 +++++++++++
 tb/tb_change_dispenser.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Greedy coin payout controller: quarter, then dime, then nickel, one hopper handshake per coin.
// Each coin costs SELECT plus at least one REQUEST cycle; an unanswered request aborts after TIMEOUT cycles.
module change_dispenser #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       q_empty,
    input  logic       d_empty,
    input  logic       n_empty,
    input  logic       coin_ack,
    output logic       coin_req,
    output logic [1:0] coin_sel,
    output logic [7:0] remaining,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [1:0] status
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SELECT   = 2'b01,
        REQUEST  = 2'b10,
        COMPLETE = 2'b11
    } state_t;

    localparam logic [1:0] SEL_NONE    = 2'b00;
    localparam logic [1:0] SEL_NICKEL  = 2'b01;
    localparam logic [1:0] SEL_DIME    = 2'b10;
    localparam logic [1:0] SEL_QUARTER = 2'b11;
    localparam logic [3:0] WAIT_LAST   = 4'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] rem_q, rem_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] wait_q, wait_d;
    logic [7:0] coin_val;

    always_comb begin
        case (sel_q)
            SEL_QUARTER: coin_val = 8'd25;
            SEL_DIME:    coin_val = 8'd10;
            SEL_NICKEL:  coin_val = 8'd5;
            default:     coin_val = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= 8'd0;
            sel_q   <= SEL_NONE;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = amount;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                // Value checks guarantee the later subtraction cannot underflow.
                if (rem_q >= 8'd25 && !q_empty) begin
                    sel_d = SEL_QUARTER;
                end else if (rem_q >= 8'd10 && !d_empty) begin
                    sel_d = SEL_DIME;
                end else if (rem_q >= 8'd5 && !n_empty) begin
                    sel_d = SEL_NICKEL;
                end else begin
                    sel_d = SEL_NONE;
                end
                wait_d  = 4'd0;
                state_d = (sel_d == SEL_NONE) ? COMPLETE : REQUEST;
            end
            REQUEST: begin
                // An ack in the final wait cycle still counts the coin.
                if (coin_ack) begin
                    rem_d   = rem_q - coin_val;
                    state_d = SELECT;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = COMPLETE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            COMPLETE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign coin_req  = (state_q == REQUEST);
    assign coin_sel  = (state_q == REQUEST) ? sel_q : SEL_NONE;
    assign remaining = rem_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == COMPLETE);
    assign short     = (state_q == COMPLETE) && (rem_q != 8'd0);
    assign status    = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: payout-level model checked every cycle, directed payouts pinned by literals.
module tb_change_dispenser;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] amount = 8'd0;
    logic       q_empty = 1'b0;
    logic       d_empty = 1'b0;
    logic       n_empty = 1'b0;
    logic       coin_ack = 1'b0;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic [7:0] remaining;
    logic       busy;
    logic       done;
    logic       short;
    logic [1:0] status;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    change_dispenser #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .amount(amount),
        .q_empty(q_empty), .d_empty(d_empty), .n_empty(n_empty), .coin_ack(coin_ack),
        .coin_req(coin_req), .coin_sel(coin_sel), .remaining(remaining), .busy(busy),
        .done(done), .short(short), .status(status)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 choosing, 2 waiting on hopper, 3 reporting; coin held in cents.
    int         m_ph = 0;
    int         m_rem = 0;
    int         m_coin = 0;
    int         m_waited = 0;

    function automatic logic [1:0] code_of(input int cents);
        if (cents == 25) return 2'b11;
        if (cents == 10) return 2'b10;
        if (cents == 5)  return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ph = 0; m_rem = 0; m_coin = 0; m_waited = 0;
        end else if (m_ph == 0) begin
            if (start) begin m_rem = amount; m_ph = 1; end
        end else if (m_ph == 1) begin
            m_coin = 0;
            if (m_rem >= 25 && !q_empty)      m_coin = 25;
            else if (m_rem >= 10 && !d_empty) m_coin = 10;
            else if (m_rem >= 5 && !n_empty)  m_coin = 5;
            m_waited = 0;
            m_ph = (m_coin != 0) ? 2 : 3;
        end else if (m_ph == 2) begin
            m_waited++;
            if (coin_ack) begin m_rem -= m_coin; m_ph = 1; end
            else if (m_waited >= TMO) m_ph = 3;
        end else begin
            m_ph = 0;
        end
    end

    logic [15:0] exp_v, act_v;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_v = {m_ph == 2, (m_ph == 2) ? code_of(m_coin) : 2'b00, m_ph != 0, m_ph == 3,
                     (m_ph == 3) && (m_rem != 0), 2'(m_ph), 8'(m_rem)};
            act_v = {coin_req, coin_sel, busy, done, short, status, remaining};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic payout(input logic [7:0] amt, input logic qe, input logic de, input logic ne,
                          input int ack_at, input bit noise,
                          output logic [5:0] seq, output int ncoins, output logic d_short,
                          output logic [7:0] d_rem, output int req_hi, output int lat);
        int hi;
        bit fin;
        seq = 6'd0; ncoins = 0; d_short = 1'b0; d_rem = 8'd0; req_hi = 0; lat = 0; hi = 0; fin = 1'b0;
        @(negedge clk);
        start = 1'b1; amount = amt; q_empty = qe; d_empty = de; n_empty = ne; coin_ack = 1'b0;
        @(posedge clk);
        lat = 1;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge clk);
            start = noise;
            amount = amt ^ 8'h5A;
            coin_ack = 1'b0;
            if (done) begin
                fin = 1'b1; d_short = short; d_rem = remaining; start = 1'b0;
            end else begin
                if (coin_req) begin
                    req_hi++;
                    if (hi == ack_at) begin
                        coin_ack = 1'b1; seq = {seq[3:0], coin_sel}; ncoins++;
                    end
                    hi++;
                end else begin
                    hi = 0;
                end
                @(posedge clk);
                lat++;
            end
        end
        if (!fin) begin
            checks++; failures++;
            $display("FAIL payout_no_done actual=no_done required=done amount=%0d", amt);
        end
    endtask

    logic [5:0] seq;
    logic       d_short;
    logic [7:0] d_rem;
    int         ncoins, req_hi, lat, ack_pct;

    initial begin
        @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'({coin_req, coin_sel, busy, done, short, status, remaining}), 0);
        chk_en = 1'b1;
        reset = 1'b0;

        payout(8'd40, 0, 0, 0, 1, 0, seq, ncoins, d_short, d_rem, req_hi, lat);
        check("p40_seq", int'(seq), 6'b111001);
        check("p40_coins", ncoins, 3);
        check("p40_short", int'(d_short), 0);
        check("p40_rem", int'(d_rem), 0);

        payout(8'd30, 0, 0, 1, 0, 0, seq, ncoins, d_short, d_rem, req_hi, lat);
        check("p30_seq", int'(seq), 6'b000011);
        check("p30_short", int'(d_short), 1);
        check("p30_rem", int'(d_rem), 5);

        payout(8'd7, 0, 0, 0, 0, 0, seq, ncoins, d_short, d_rem, req_hi, lat);
        check("p7_seq", int'(seq), 6'b000001);
        check("p7_short", int'(d_short), 1);
        check("p7_rem", int'(d_rem), 2);

        payout(8'd25, 0, 0, 0, -1, 0, seq, ncoins, d_short, d_rem, req_hi, lat);
        check("tmo_req_cycles", req_hi, 15);
        check("tmo_short", int'(d_short), 1);
        check("tmo_rem", int'(d_rem), 25);

        payout(8'd25, 0, 0, 0, 14, 0, seq, ncoins, d_short, d_rem, req_hi, lat);
        check("lastack_req_cycles", req_hi, 15);
        check("lastack_short", int'(d_short), 0);
        check("lastack_rem", int'(d_rem), 0);

        // Reset in the middle of a request, with a coincident ack that must be dropped.
        @(negedge clk);
        start = 1'b1; amount = 8'd25;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && !coin_req; c++) @(negedge clk);
        check("rst_reached_request", int'(coin_req), 1);
        reset = 1'b1; coin_ack = 1'b1;
        @(negedge clk);
        reset = 1'b0; coin_ack = 1'b0;
        check("rst_status", int'(status), 0);
        check("rst_coin_req", int'(coin_req), 0);
        check("rst_remaining", int'(remaining), 0);

        payout(8'd10, 0, 0, 0, 0, 0, seq, ncoins, d_short, d_rem, req_hi, lat);
        check("after_rst_seq", int'(seq), 6'b000010);
        check("after_rst_rem", int'(d_rem), 0);

        payout(8'd55, 0, 0, 0, 2, 1, seq, ncoins, d_short, d_rem, req_hi, lat);
        check("busy_start_seq", int'(seq), 6'b111101);
        check("busy_start_rem", int'(d_rem), 0);

        payout(8'd0, 0, 0, 0, 0, 0, seq, ncoins, d_short, d_rem, req_hi, lat);
        check("zero_latency", lat, 2);
        check("zero_short", int'(d_short), 0);

        ack_pct = 20;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (i % 1000 == 0) ack_pct = $urandom_range(3, 60);
            reset = ($urandom_range(0, 599) == 0);
            start = ($urandom_range(0, 3) == 0);
            amount = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 60)) : 8'($urandom);
            if ($urandom_range(0, 7) == 0) q_empty = ~q_empty;
            if ($urandom_range(0, 7) == 0) d_empty = ~d_empty;
            if ($urandom_range(0, 7) == 0) n_empty = ~n_empty;
            coin_ack = ($urandom_range(0, 99) < ack_pct);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
